// File: rtl/multicycle_controller.sv
// Multicycle control sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, driving one phase of datapath strobes per cycle.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  state_t            state;
  logic [6:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_op_for(input logic [6:0] op);
    case (op)
      OP_BR:           alu_op_for = 2'b01;
      OP_R, OP_I:      alu_op_for = 2'b10;
      OP_JAL, OP_JALR: alu_op_for = 2'b11;
      default:         alu_op_for = 2'b00;
    endcase
  endfunction

  // Sequencer; wait_cnt defaults to clear so every state change restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      wait_cnt   <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_IMEM;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= Opcode;
          if (is_legal(Opcode)) begin
            state <= S_EXECUTE;
          end else begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXECUTE: begin
          if (op_q == OP_LW || op_q == OP_SW) begin
            state <= S_MEMORY;
          end else if (op_q == OP_BR) begin
            state   <= S_FETCH;
            instret <= instret + CNT_W'(1);
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (dmem_ready) begin
            if (op_q == OP_LW) begin
              state <= S_WRITEBACK;
            end else begin
              state   <= S_FETCH;
              instret <= instret + CNT_W'(1);
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_DMEM;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WRITEBACK: begin
          state   <= S_FETCH;
          instret <= instret + CNT_W'(1);
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from state and latched opcode; ready inputs only gate the
  // completion pulses inside FETCH and MEMORY
  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    busy     = 1'b0;
    case (state)
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      S_DECODE: busy = 1'b1;
      S_EXECUTE: begin
        busy   = 1'b1;
        ALUOp  = alu_op_for(op_q);
        ALUSrc = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_I);
        if (op_q == OP_BR) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_MEMORY: begin
        busy     = 1'b1;
        ALUSrc   = 1'b1;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
        PCWrite  = (op_q == OP_SW) && dmem_ready;
      end
      S_WRITEBACK: begin
        busy     = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (op_q == OP_LW);
        ALUOp    = alu_op_for(op_q);
        Branch   = (op_q == OP_JAL) || (op_q == OP_JALR);
      end
      default: ;
    endcase
  end

endmodule
